// File: rtl/pico_exec_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/WB sequencer for the picoMIPS core.
// Inserts stall cycles for the multiplier and the switch-input handshake.
module pico_exec_sequencer #(
    parameter int unsigned MUL_CYCLES = 4,
    parameter logic [3:0]  OP_MUL     = 4'b0110,
    parameter logic [3:0]  OP_LDSW    = 4'b1010
) (
    input  logic        clk,
    input  logic        nReset,
    input  logic        run,
    input  logic [3:0]  opcode,
    input  logic        dec_w,
    input  logic        dec_pcincr,
    input  logic        dec_pcabs,
    input  logic        dec_pcrel,
    input  logic        sw_valid,
    output logic        sw_ack,
    output logic        ir_load,
    output logic        reg_we,
    output logic        pc_en,
    output logic        pc_incr,
    output logic        pc_abs,
    output logic        pc_rel,
    output logic        mul_busy,
    output logic [2:0]  state,
    output logic [15:0] instr_count
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXEC    = 3'd3,
        S_MULWAIT = 3'd4,
        S_SWWAIT  = 3'd5,
        S_WB      = 3'd6
    } seqState_t;

    localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);

    seqState_t   state_q, state_d;
    logic [3:0]  mulCnt_q, mulCnt_d;
    logic [15:0] instrCount_q, instrCount_d;

    always_ff @(posedge clk) begin
        if (!nReset) begin
            state_q      <= S_IDLE;
            mulCnt_q     <= 4'd0;
            instrCount_q <= 16'd0;
        end else begin
            state_q      <= state_d;
            mulCnt_q     <= mulCnt_d;
            instrCount_q <= instrCount_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        mulCnt_d     = mulCnt_q;
        instrCount_d = instrCount_q;
        ir_load      = 1'b0;
        reg_we       = 1'b0;
        pc_en        = 1'b0;
        pc_incr      = 1'b0;
        pc_abs       = 1'b0;
        pc_rel       = 1'b0;
        mul_busy     = 1'b0;
        sw_ack       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                ir_load = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (opcode == OP_MUL) begin
                    state_d  = S_MULWAIT;
                    mulCnt_d = MUL_LOAD;
                end else if (opcode == OP_LDSW) begin
                    state_d = S_SWWAIT;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = S_WB;
            end
            S_MULWAIT: begin
                mul_busy = 1'b1;
                if (mulCnt_q == 4'd0) state_d = S_WB;
                else                  mulCnt_d = mulCnt_q - 4'd1;
            end
            S_SWWAIT: begin
                if (sw_valid) begin
                    sw_ack  = 1'b1;
                    state_d = S_WB;
                end
            end
            S_WB: begin
                // Single retirement point: the only cycle that writes registers or moves the PC.
                pc_en        = 1'b1;
                reg_we       = dec_w;
                pc_abs       = dec_pcabs;
                pc_rel       = dec_pcrel & ~dec_pcabs;
                pc_incr      = dec_pcincr & ~dec_pcabs & ~dec_pcrel;
                instrCount_d = instrCount_q + 16'd1;
                state_d      = run ? S_FETCH : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign state       = state_q;
    assign instr_count = instrCount_q;

endmodule

// File: tb/tb_pico_exec_sequencer.sv
// Randomised self-checking bench for pico_exec_sequencer; expectations come from
// per-instruction latency arithmetic and a retirement counter.
module tb_pico_exec_sequencer;

    localparam int         MC      = 4;
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_BEQ  = 4'd3;
    localparam logic [3:0] OP_MUL  = 4'd6;
    localparam logic [3:0] OP_LDSW = 4'd10;

    logic        clk = 1'b0;
    logic        nReset = 1'b0;
    logic        run = 1'b0;
    logic [3:0]  opcode = 4'd0;
    logic        decW = 1'b0, decIncr = 1'b0, decAbs = 1'b0, decRel = 1'b0;
    logic        swValid = 1'b0;

    logic        swAck, irLoad, regWe, pcEn, pcIncr, pcAbs, pcRel, mulBusy;
    logic [2:0]  seqState;
    logic [15:0] instrCount;

    logic        u1SwAck, u1IrLoad, u1RegWe, u1PcEn, u1PcIncr, u1PcAbs, u1PcRel, u1MulBusy;
    logic [2:0]  u1State;
    logic [15:0] u1Count;

    int          testsRun = 0;
    int          failCount = 0;
    logic [15:0] expCount = 16'd0;

    pico_exec_sequencer #(.MUL_CYCLES(MC), .OP_MUL(OP_MUL), .OP_LDSW(OP_LDSW)) dut (
        .clk(clk), .nReset(nReset), .run(run), .opcode(opcode),
        .dec_w(decW), .dec_pcincr(decIncr), .dec_pcabs(decAbs), .dec_pcrel(decRel),
        .sw_valid(swValid), .sw_ack(swAck), .ir_load(irLoad), .reg_we(regWe),
        .pc_en(pcEn), .pc_incr(pcIncr), .pc_abs(pcAbs), .pc_rel(pcRel),
        .mul_busy(mulBusy), .state(seqState), .instr_count(instrCount)
    );

    pico_exec_sequencer #(.MUL_CYCLES(1), .OP_MUL(OP_MUL), .OP_LDSW(OP_LDSW)) dut1 (
        .clk(clk), .nReset(nReset), .run(run), .opcode(opcode),
        .dec_w(decW), .dec_pcincr(decIncr), .dec_pcabs(decAbs), .dec_pcrel(decRel),
        .sw_valid(swValid), .sw_ack(u1SwAck), .ir_load(u1IrLoad), .reg_we(u1RegWe),
        .pc_en(u1PcEn), .pc_incr(u1PcIncr), .pc_abs(u1PcAbs), .pc_rel(u1PcRel),
        .mul_busy(u1MulBusy), .state(u1State), .instr_count(u1Count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic checkAll(input string ph, input int eState, input int eIr, input int eMul,
                            input int eAck, input int eWe, input int eEn, input int eInc,
                            input int eAbs, input int eRel);
        checkOutput({ph, ".state"},    32'(seqState),   32'(eState));
        checkOutput({ph, ".ir_load"},  32'(irLoad),     32'(eIr));
        checkOutput({ph, ".mul_busy"}, 32'(mulBusy),    32'(eMul));
        checkOutput({ph, ".sw_ack"},   32'(swAck),      32'(eAck));
        checkOutput({ph, ".reg_we"},   32'(regWe),      32'(eWe));
        checkOutput({ph, ".pc_en"},    32'(pcEn),       32'(eEn));
        checkOutput({ph, ".pc_incr"},  32'(pcIncr),     32'(eInc));
        checkOutput({ph, ".pc_abs"},   32'(pcAbs),      32'(eAbs));
        checkOutput({ph, ".pc_rel"},   32'(pcRel),      32'(eRel));
        checkOutput({ph, ".count"},    32'(instrCount), 32'(expCount));
    endtask

    // Runs one instruction, assuming the next rising edge enters FETCH.
    // Cycle 1 is FETCH; WB lands at 4, 3+MC, or one cycle after sw_valid rises.
    task automatic applyStimulus(input logic [3:0] op, input logic w, input logic inc,
                                 input logic abs, input logic rel, input int swDelay,
                                 input logic runNext);
        int len, eState, eInc, eAbs, eRel;
        bit isMul, isSw;
        isMul = (op == OP_MUL);
        isSw  = (op == OP_LDSW);
        len   = isMul ? 3 + MC : (isSw ? 4 + swDelay : 4);
        for (int c = 1; c <= len; c++) begin
            @(negedge clk);
            if (c == 1) begin
                opcode = op; decW = w; decIncr = inc; decAbs = abs; decRel = rel;
            end
            run = (c == len) ? runNext : 1'($urandom_range(0, 1));
            if (isSw && c >= 3 && c < len) swValid = (c == len - 1);
            else                           swValid = 1'($urandom_range(0, 1));
            #1;
            if (c == 1)        eState = 1;
            else if (c == 2)   eState = 2;
            else if (c == len) eState = 6;
            else               eState = isMul ? 4 : (isSw ? 5 : 3);
            eInc = 0; eAbs = 0; eRel = 0;
            if (c == len) begin
                if (abs)      eAbs = 1;
                else if (rel) eRel = 1;
                else if (inc) eInc = 1;
            end
            checkAll($sformatf("op%0d.c%0d", op, c), eState, int'(c == 1), int'(eState == 4),
                     int'(eState == 5 && swValid), int'(c == len && w), int'(c == len),
                     eInc, eAbs, eRel);
        end
        expCount = expCount + 16'd1;
        if (!runNext) begin
            repeat ($urandom_range(1, 3)) begin
                @(negedge clk);
                run = 1'b0;
                swValid = 1'($urandom_range(0, 1));
                #1;
                checkAll("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0);
            end
            run = 1'b1;
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0] op;
        // Reset with run held high, then release with run low.
        nReset = 1'b0; run = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        nReset = 1'b1; run = 1'b0;
        repeat (3) begin
            #1;
            checkAll("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
            @(negedge clk);
        end
        run = 1'b1;

        applyStimulus(OP_ADD,  1'b1, 1'b1, 1'b0, 1'b0, 0,  1'b1);
        applyStimulus(OP_MUL,  1'b1, 1'b1, 1'b0, 1'b0, 0,  1'b1);
        applyStimulus(OP_LDSW, 1'b1, 1'b1, 1'b0, 1'b0, 10, 1'b1);
        applyStimulus(OP_BEQ,  1'b0, 1'b0, 1'b0, 1'b1, 0,  1'b1);
        applyStimulus(4'd4,    1'b1, 1'b1, 1'b1, 1'b1, 0,  1'b0);

        for (int i = 0; i < 200; i++) begin
            op = 4'($urandom_range(0, 15));
            applyStimulus(op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          int'($urandom_range(0, 8)), 1'($urandom_range(0, 3) != 0));
        end
        applyStimulus(OP_ADD, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);

        // Reset in the second MULWAIT cycle abandons the MUL with no write.
        swValid = 1'b0;
        @(negedge clk); opcode = OP_MUL; decW = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); nReset = 1'b0;
        #1;
        checkOutput("mulrst.before.state", 32'(seqState), 32'd4);
        @(negedge clk); nReset = 1'b1; run = 1'b0;
        expCount = 16'd0;
        #1;
        checkAll("mulrst.after", 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // MUL_CYCLES=1 instance: one MULWAIT cycle, WB in cycle 4.
        @(negedge clk); opcode = OP_MUL; decW = 1'b1; run = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            #1;
            checkOutput($sformatf("mc1.c%0d.state", c), 32'(u1State),
                        (c == 1) ? 32'd1 : (c == 2) ? 32'd2 : (c == 3) ? 32'd4 : 32'd6);
            checkOutput($sformatf("mc1.c%0d.mul_busy", c), 32'(u1MulBusy), 32'(c == 3));
            checkOutput($sformatf("mc1.c%0d.reg_we", c), 32'(u1RegWe), 32'(c == 4));
        end
        run = 1'b0; nReset = 1'b0;
        @(negedge clk); nReset = 1'b1;
        expCount = 16'd0;
        #1;
        checkAll("mc1.reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Preload the retirement counter near its top to exercise the wrap.
        force dut.instrCount_q = 16'hFFFE;
        @(posedge clk);
        @(negedge clk);
        release dut.instrCount_q;
        expCount = 16'hFFFE;
        #1;
        checkAll("wrap.preload", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        run = 1'b1;
        applyStimulus(OP_ADD, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b1);
        applyStimulus(OP_ADD, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b1);
        applyStimulus(OP_ADD, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        checkOutput("wrap.final", 32'(instrCount), 32'h0001);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
